// File: rtl/ram_burst_master.sv
// ============================================================================
//  Module      : ram_burst_master
//  Description : Burst master that streams write beats into, and read beats
//                out of, a single-port RAM with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t            r_state_q,  w_state_d;
    logic [ADDR_W-1:0] r_addr_q,   w_addr_d;
    logic [ADDR_W-1:0] r_cnt_q,    w_cnt_d;
    logic [DATA_W-1:0] r_rdata_q,  w_rdata_d;
    logic              r_rvalid_q, w_rvalid_d;

    logic w_wr_beat;
    logic w_rd_issue;

    // Every strobe is gated by rst so nothing reaches the RAM during reset.
    assign w_wr_beat  = rst && (r_state_q == S_WRITE) && wdata_valid;
    assign w_rd_issue = rst && (r_state_q == S_READ) && (!r_rvalid_q || rdata_ready);

    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_cnt_d    = r_cnt_q;
        w_rdata_d  = r_rdata_q;
        w_rvalid_d = r_rvalid_q;

        if (r_rvalid_q && rdata_ready) begin
            w_rvalid_d = 1'b0;
        end

        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_addr_d  = req_addr;
                    w_cnt_d   = req_len;
                    w_state_d = req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (w_wr_beat) begin
                    w_addr_d = r_addr_q + c_addr_one;
                    if (r_cnt_q == '0) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_cnt_d = r_cnt_q - c_addr_one;
                    end
                end
            end
            S_READ: begin
                if (w_rd_issue) begin
                    w_rdata_d  = mem_rdata;
                    w_rvalid_d = 1'b1;
                    w_addr_d   = r_addr_q + c_addr_one;
                    if (r_cnt_q == '0) begin
                        w_state_d = S_DRAIN;
                    end else begin
                        w_cnt_d = r_cnt_q - c_addr_one;
                    end
                end
            end
            S_DRAIN: begin
                if (!r_rvalid_q || rdata_ready) begin
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q  <= S_IDLE;
            r_addr_q   <= '0;
            r_cnt_q    <= '0;
            r_rdata_q  <= '0;
            r_rvalid_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_addr_q   <= w_addr_d;
            r_cnt_q    <= w_cnt_d;
            r_rdata_q  <= w_rdata_d;
            r_rvalid_q <= w_rvalid_d;
        end
    end

    assign req_ready   = rst && (r_state_q == S_IDLE);
    assign wdata_ready = rst && (r_state_q == S_WRITE);
    assign mem_wr      = w_wr_beat;
    assign mem_rd      = w_rd_issue;
    assign mem_addr    = ((r_state_q == S_WRITE) || (r_state_q == S_READ)) ? r_addr_q : '0;
    assign mem_wdata   = (r_state_q == S_WRITE) ? wdata : '0;
    assign rdata       = r_rdata_q;
    assign rdata_valid = r_rvalid_q;
    assign busy        = rst && (r_state_q != S_IDLE);
    assign done        = rst && (r_state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_master.sv
// ============================================================================
//  Module      : tb_ram_burst_master
//  Description : Scoreboard bench for ram_burst_master with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [4:0]  req_len;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic        mem_wr;
    logic        mem_rd;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    wire  [31:0] mem_rdata;
    logic        busy;
    logic        done;

    logic [31:0] ram [32];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [4:0]  exp_waddr [$];
    logic [31:0] exp_wdata [$];
    logic [4:0]  exp_raddr [$];
    logic [31:0] exp_rdata [$];

    ram_burst_master #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? ram[mem_addr] : {32{1'bz}};

    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every RAM strobe and every accepted read beat
    // against the expectations queued by the stimulus tasks.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rdata = '0;
    always @(negedge clk) begin
        chk("strobe_exclusive", {63'd0, mem_wr && mem_rd}, 64'd0);
        if (mem_wr) begin
            if (exp_waddr.size() == 0) begin
                chk("unexpected_mem_wr", 64'd1, 64'd0);
            end else begin
                chk("wr_addr", {59'd0, mem_addr}, {59'd0, exp_waddr.pop_front()});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, exp_wdata.pop_front()});
            end
        end
        if (mem_rd) begin
            if (exp_raddr.size() == 0) begin
                chk("unexpected_mem_rd", 64'd1, 64'd0);
            end else begin
                chk("rd_addr", {59'd0, mem_addr}, {59'd0, exp_raddr.pop_front()});
            end
        end
        if (prev_stall && rdata_valid) begin
            chk("rdata_stable", {32'd0, rdata}, {32'd0, prev_rdata});
        end
        if (rdata_valid && !rdata_ready) begin
            chk("mem_rd_stalled", {63'd0, mem_rd}, 64'd0);
        end
        if (rdata_valid && rdata_ready) begin
            if (exp_rdata.size() == 0) begin
                chk("unexpected_rbeat", 64'd1, 64'd0);
            end else begin
                chk("rdata", {32'd0, rdata}, {32'd0, exp_rdata.pop_front()});
            end
        end
        prev_stall = rdata_valid && !rdata_ready;
        prev_rdata = rdata;
        if (done) begin
            done_cnt++;
            chk("done_after_last_beat", 64'(exp_rdata.size()), 64'd0);
            chk("busy_in_done", {63'd0, busy}, 64'd1);
        end
    end

    task automatic issue_req(input logic wr, input logic [4:0] addr, input logic [4:0] len);
        logic got;
        got = 1'b0;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk); #1;
            if (got) break;
        end
        req_valid = 1'b0;
        chk("req_accepted", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", {63'd0, got}, 64'd1);
        exp_done++;
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        @(posedge clk); #1;
    endtask

    task automatic write_beat(input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        wdata       = d;
        wdata_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = wdata_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        chk("wbeat_accepted", {63'd0, acc}, 64'd1);
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [4:0] len,
                            input logic [31:0] base, input logic [3:0] gaps);
        logic [4:0] a;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            exp_waddr.push_back(a);
            exp_wdata.push_back(base + 32'(i));
            a = a + 5'd1;
        end
        issue_req(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (i < 4 && gaps[i]) begin
                wdata_valid = 1'b0;
                @(posedge clk); #1;
            end
            write_beat(base + 32'(i));
        end
        wdata_valid = 1'b0;
        wait_done();
        chk("wr_queue_empty", 64'(exp_waddr.size()), 64'd0);
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [4:0] len,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic stall);
        logic [4:0]  a;
        logic [31:0] dv [4];
        logic        seen;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            exp_raddr.push_back(a);
            exp_rdata.push_back(dv[i]);
            a = a + 5'd1;
        end
        issue_req(1'b0, addr, len);
        if (stall) begin
            seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (rdata_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("first_rbeat_seen", {63'd0, seen}, 64'd1);
            @(posedge clk); #1;
            rdata_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rdata_ready = 1'b1;
        end
        wait_done();
        chk("rd_queue_empty", 64'(exp_rdata.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b1;
        for (int i = 0; i < 32; i++) ram[i] = 32'hDEAD_0000 + 32'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_mem_addr", {59'd0, mem_addr}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        do_write(5'd3, 5'd3, 32'hA0, 4'b0000);
        do_read(5'd3, 5'd3, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);
        do_write(5'd30, 5'd3, 32'hB0, 4'b0000);
        do_read(5'd3, 5'd2, 32'hA0, 32'hA1, 32'hA2, 32'h0, 1'b1);
        do_write(5'd8, 5'd3, 32'hC0, 4'b1010);
        do_read(5'd8, 5'd3, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b0);
        do_read(5'd30, 5'd3, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b0);

        // Abort a 4-beat write while the second beat is being offered.
        exp_waddr.push_back(5'd12);
        exp_wdata.push_back(32'hD0);
        issue_req(1'b1, 5'd12, 5'd3);
        write_beat(32'hD0);
        wdata = 32'hD1;
        wdata_valid = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_mem_wr", {63'd0, mem_wr}, 64'd0);
            chk("abort_wdata_ready", {63'd0, wdata_ready}, 64'd0);
            chk("abort_req_ready", {63'd0, req_ready}, 64'd0);
            chk("abort_busy", {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        wdata_valid = 1'b0;
        @(negedge clk);
        chk("abort_release_req_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_no_done", 64'(done_cnt), 64'(exp_done));
        chk("abort_wr_queue", 64'(exp_waddr.size()), 64'd0);
        @(posedge clk); #1;
        do_read(5'd12, 5'd1, 32'hD0, 32'hDEAD_000D, 32'h0, 32'h0, 1'b0);
        do_write(5'd16, 5'd1, 32'hE0, 4'b0000);
        do_read(5'd16, 5'd1, 32'hE0, 32'hE1, 32'h0, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL provide parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 SHALL provide parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  in  1  burst request valid.
REQ-007 SHALL have port req_ready  out  1  burst request accepted when high with req_valid.
REQ-008 SHALL have port req_write  in  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have port req_addr  in  ADDR_W  burst start address.
REQ-010 SHALL have port req_len  in  ADDR_W  beats minus one (0 = 1 beat, 31 = 32 beats).
REQ-011 SHALL have port wdata  in  DATA_W  write beat data.
REQ-012 SHALL have port wdata_valid  in  1  write beat valid.
REQ-013 SHALL have port wdata_ready  out  1  write beat accepted when high with wdata_valid.
REQ-014 SHALL have port rdata  out  DATA_W  registered read beat data.
REQ-015 SHALL have port rdata_valid  out  1  read beat valid.
REQ-016 SHALL have port rdata_ready  in  1  downstream accepts read beat.
REQ-017 SHALL have port mem_wr / mem_rd  out  1 each  RAM write / read strobes.
REQ-018 SHALL have port mem_addr  out  ADDR_W  RAM address.
REQ-019 SHALL have port mem_wdata  out  DATA_W  RAM write data.
REQ-020 SHALL have port mem_rdata  in  DATA_W  RAM read data (combinational from RAM, high-Z when mem_rd low).
REQ-021 SHALL have port busy  out  1  burst in progress; done  out  1  one-cycle burst completion pulse.

Function
REQ-022 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-023 SHALL drive req_ready = 1 only in IDLE with rst high; handshake captures addr, remaining count = req_len, direction; next state WRITE or READ.
REQ-024 In WRITE, SHALL drive wdata_ready = 1 and mem_wr = wdata_valid combinationally, mem_wdata = wdata, mem_addr = current address; each accepted beat commits at that edge.
REQ-025 In READ, SHALL drive mem_rd = 1 when rdata_valid == 0 or rdata_ready == 1; mem_rdata is sampled only in cycles where mem_rd = 1, into rdata, with rdata_valid set at that edge.
REQ-026 SHALL clear rdata_valid on rdata_valid && rdata_ready when no new beat is captured in the same cycle; rdata holds stable while rdata_valid && !rdata_ready.
REQ-027 SHALL increment the address after each issued beat, wrapping 31 -> 0 modulo 2^ADDR_W.
REQ-028 Last write beat SHALL transition WRITE -> DONE; last read issue SHALL transition READ -> DRAIN.
REQ-029 DRAIN SHALL wait until the final rdata beat is accepted, then go to DONE.
REQ-030 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-031 SHALL hold busy = 1 in WRITE, READ, DRAIN, DONE; mem_wr = mem_rd = 0 outside WRITE/READ; mem_addr = 0 in IDLE.
REQ-032 SHALL keep mem_wr and mem_rd mutually exclusive at all times.
REQ-033 SHALL ignore req_valid while busy; no request queuing.

Reset
REQ-034 While rst = 0 at a rising edge, SHALL enter IDLE, clear count/address, rdata = 0, rdata_valid = 0.
REQ-035 While rst = 0, SHALL drive req_ready, wdata_ready, mem_wr, mem_rd, busy, done = 0.
REQ-036 Reset mid-burst SHALL abort the burst: no further mem_wr/mem_rd after that edge, and pending rdata is dropped.

Verification
REQ-037 Write burst: addr 3, len 3, wdata 0xA0..0xA3 with wdata_valid constant -> mem_wr on 4 consecutive cycles at addrs 3,4,5,6; done pulses once.
REQ-038 Read-back: read addr 3, len 3, rdata_ready = 1 -> rdata 0xA0..0xA3 in order; rdata_valid 4 cycles; done after the last beat.
REQ-039 Wrap: write addr 30, len 3 -> mem_addr sequence 30, 31, 0, 1.
REQ-040 Backpressure: read len 2 with rdata_ready low 3 cycles after the first beat -> rdata stable, mem_rd = 0 while stalled, no beat lost/duplicated; done only after the third beat is accepted.
REQ-041 Write stall: wdata_valid gaps between beats -> mem_wr only on valid cycles; beat count and addresses still correct.
REQ-042 Reset mid-burst: rst low during beat 2 of a 4-beat write -> mem_wr = 0 from that edge; after release, req_ready = 1 and a new burst runs normally.
